// File: rtl/dvp_frame_tx.sv
// OV7670-style DVP camera-side transmitter: emits RGB565 test-pattern frames on p_clock/vsync/href/p_data.
// Optional back-to-back frame mode is enabled by defining DVP_TX_CONTINUOUS_EN (adds the continuous input).
module dvp_frame_tx #(
  parameter int H_ACTIVE    = 32,
  parameter int V_ACTIVE    = 32,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 2,
  parameter int VFP_LINES   = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] pattern_sel,
`ifdef DVP_TX_CONTINUOUS_EN
  input  logic       continuous,
`endif
  output logic       p_clock,
  output logic       vsync,
  output logic       href,
  output logic [7:0] p_data,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  localparam int LINE = 2 * H_ACTIVE + H_BLANK;
  localparam logic [15:0] VS_LAST  = 16'(VSYNC_LINES * LINE - 1);
  localparam logic [15:0] VBP_LAST = 16'((VBP_LINES > 0) ? VBP_LINES * LINE - 1 : 0);
  localparam logic [15:0] VFP_LAST = 16'((VFP_LINES > 0) ? VFP_LINES * LINE - 1 : 0);
  localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
  localparam logic [15:0] COL_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] ROW_END  = 16'(V_ACTIVE);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_HBLANK, S_VFP, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] row, row_n;
  logic [15:0] col, col_n;
  logic        lo_byte, lo_byte_n;
  logic [1:0]  pat, pat_n;
  logic        start_pend, start_pend_n;
  logic        busy_n;
  logic [7:0]  frame_cnt_n;
  logic [15:0] pix_n;
  logic [7:0]  p_data_n;
  logic        tick;

  function automatic logic [15:0] pixel(input logic [1:0] sel, input logic [15:0] r,
                                        input logic [15:0] c);
    logic [15:0] px;
    case (sel)
      2'd0:    px = 16'hF800;
      2'd1:    px = c;
      2'd2:    px = (r[3] ^ c[3]) ? 16'hFFFF : 16'h0000;
      default: px = {r[7:0], c[7:0]};
    endcase
    return px;
  endfunction

  // Frame sequencing only advances on the p_clock falling edge so outputs are settled at its rising edge.
  assign tick = p_clock;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    row_n        = row;
    col_n        = col;
    lo_byte_n    = lo_byte;
    pat_n        = pat;
    start_pend_n = start_pend;
    busy_n       = busy;
    frame_cnt_n  = frame_cnt;

    if (state == S_IDLE && start) begin
      start_pend_n = 1'b1;
      busy_n       = 1'b1;
    end

    if (state == S_DONE) begin
      frame_cnt_n = frame_cnt + 8'd1;
      state_n     = S_IDLE;
      busy_n      = 1'b0;
`ifdef DVP_TX_CONTINUOUS_EN
      // Re-arm the request so the next tick re-enters VSYNC with a fresh pattern_sel.
      if (continuous) begin
        start_pend_n = 1'b1;
        busy_n       = 1'b1;
      end
`endif
    end else if (tick) begin
      case (state)
        S_IDLE: begin
          if (start_pend) begin
            start_pend_n = 1'b0;
            pat_n        = pattern_sel;
            state_n      = S_VSYNC;
            cnt_n        = 16'd0;
          end
        end
        S_VSYNC: begin
          if (cnt == VS_LAST) begin
            cnt_n     = 16'd0;
            row_n     = 16'd0;
            col_n     = 16'd0;
            lo_byte_n = 1'b0;
            state_n   = (VBP_LINES > 0) ? S_VBP : S_ACTIVE;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        S_VBP: begin
          if (cnt == VBP_LAST) begin
            cnt_n     = 16'd0;
            row_n     = 16'd0;
            col_n     = 16'd0;
            lo_byte_n = 1'b0;
            state_n   = S_ACTIVE;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        S_ACTIVE: begin
          lo_byte_n = ~lo_byte;
          if (lo_byte) begin
            if (col == COL_LAST) begin
              col_n   = 16'd0;
              cnt_n   = 16'd0;
              state_n = S_HBLANK;
            end else begin
              col_n = col + 16'd1;
            end
          end
        end
        S_HBLANK: begin
          if (cnt == HB_LAST) begin
            cnt_n     = 16'd0;
            row_n     = row + 16'd1;
            col_n     = 16'd0;
            lo_byte_n = 1'b0;
            if (row_n < ROW_END) state_n = S_ACTIVE;
            else                 state_n = (VFP_LINES > 0) ? S_VFP : S_DONE;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        S_VFP: begin
          if (cnt == VFP_LAST) begin
            cnt_n   = 16'd0;
            state_n = S_DONE;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    pix_n    = pixel(pat_n, row_n, col_n);
    p_data_n = 8'd0;
    if (state_n == S_ACTIVE) p_data_n = lo_byte_n ? pix_n[7:0] : pix_n[15:8];
  end

  // Pin outputs are registered from the next state so they change together with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_clock    <= 1'b0;
      state      <= S_IDLE;
      cnt        <= 16'd0;
      row        <= 16'd0;
      col        <= 16'd0;
      lo_byte    <= 1'b0;
      pat        <= 2'd0;
      start_pend <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= 8'd0;
      frame_done <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      p_data     <= 8'd0;
    end else begin
      p_clock    <= ~p_clock;
      state      <= state_n;
      cnt        <= cnt_n;
      row        <= row_n;
      col        <= col_n;
      lo_byte    <= lo_byte_n;
      pat        <= pat_n;
      start_pend <= start_pend_n;
      busy       <= busy_n;
      frame_cnt  <= frame_cnt_n;
      frame_done <= (state_n == S_DONE);
      vsync      <= (state_n == S_VSYNC);
      href       <= (state_n == S_ACTIVE);
      p_data     <= p_data_n;
    end
  end

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Scoreboard bench for dvp_frame_tx: expected per-pclk {vsync,href,p_data} records are queued at start.
module tb_dvp_frame_tx;

  localparam int HA = 32, VA = 32, HB = 16, VSL = 3, VBPL = 2, VFPL = 2;
  localparam int L = 2 * HA + HB;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [1:0] pattern_sel;
`ifdef DVP_TX_CONTINUOUS_EN
  logic       continuous;
`endif
  logic       p_clock, vsync, href, busy, frame_done;
  logic [7:0] p_data, frame_cnt;

  int         n_vec = 0;
  int         n_err = 0;
  int         fd_seen = 0;
  int         waited;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  dvp_frame_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VSL), .VBP_LINES(VBPL), .VFP_LINES(VFPL)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .pattern_sel(pattern_sel),
`ifdef DVP_TX_CONTINUOUS_EN
    .continuous(continuous),
`endif
    .p_clock(p_clock), .vsync(vsync), .href(href), .p_data(p_data),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(negedge clk);
    if (frame_done === 1'b1) fd_seen++;
  endtask

  function automatic logic [15:0] model_pix(input int pat, input int r, input int c);
    logic [15:0] rr, cc;
    rr = 16'(r);
    cc = 16'(c);
    case (pat)
      0:       return 16'hF800;
      1:       return cc;
      2:       return (rr[3] ^ cc[3]) ? 16'hFFFF : 16'h0000;
      default: return {rr[7:0], cc[7:0]};
    endcase
  endfunction

  task automatic push_frame(input int pat);
    logic [15:0] p;
    for (int i = 0; i < VSL * L; i++) exp_q.push_back(10'h200);
    for (int i = 0; i < VBPL * L; i++) exp_q.push_back(10'h000);
    for (int r = 0; r < VA; r++) begin
      for (int c = 0; c < HA; c++) begin
        p = model_pix(pat, r, c);
        exp_q.push_back({2'b01, p[15:8]});
        exp_q.push_back({2'b01, p[7:0]});
      end
      for (int i = 0; i < HB; i++) exp_q.push_back(10'h000);
    end
    for (int i = 0; i < VFPL * L; i++) exp_q.push_back(10'h000);
  endtask

  task automatic pulse_start(input int pat);
    pattern_sel = 2'(pat);
    step_clk();
    start = 1'b1;
    step_clk();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Consumes queued records one per pclk from the first vsync sample; poke pulses start at that clk count.
  task automatic run_frame(input int poke, output int wait_pclk);
    int k, idx, limit;
    bit go;
    logic [9:0] rec;
    k = 0; idx = 0; go = 0; wait_pclk = 0;
    fd_seen = 0;
    limit = 2 * exp_q.size() + 400;
    while (!go) begin
      step_clk(); k++;
      start = (k == poke);
      if (p_clock === 1'b1 && vsync === 1'b1) go = 1;
      else if (p_clock === 1'b1) wait_pclk++;
      if (!go && k > 200) begin
        check("vsync_wait", 32'(vsync), 32'd1);
        exp_q.delete();
        start = 1'b0;
        return;
      end
    end
    while (exp_q.size() > 0) begin
      if (p_clock === 1'b1) begin
        rec = exp_q.pop_front();
        check($sformatf("frame[%0d] {vs,hr,data}", idx), 32'({vsync, href, p_data}), 32'(rec));
        idx++;
      end
      if (exp_q.size() > 0) begin
        step_clk(); k++;
        start = (k == poke);
        if (k > limit) begin
          check("frame_timeout", 32'(exp_q.size()), 32'd0);
          exp_q.delete();
        end
      end
    end
    start = 1'b0;
    step_clk();
    step_clk();
  endtask

  initial begin
    int base;
    resetn = 1'b0;
    start = 1'b0;
    pattern_sel = 2'd0;
`ifdef DVP_TX_CONTINUOUS_EN
    continuous = 1'b0;
`endif
    // Reset state
    repeat (3) step_clk();
    check("rst p_clock", 32'(p_clock), 32'd0);
    check("rst vsync", 32'(vsync), 32'd0);
    check("rst href", 32'(href), 32'd0);
    check("rst p_data", 32'(p_data), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    check("rst frame_cnt", 32'(frame_cnt), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_clk();
      check($sformatf("p_clock toggle %0d", i), 32'(p_clock), 32'(i % 2 == 0));
      check("idle vsync|href", 32'({vsync, href}), 32'd0);
    end

    // Pattern 3 single frame
    push_frame(3);
    pulse_start(3);
    run_frame(0, waited);
    check("A frame_done pulses", 32'(fd_seen), 32'd1);
    check("A frame_cnt", 32'(frame_cnt), 32'd1);
    check("A busy", 32'(busy), 32'd0);

    // Pattern 0 solid
    push_frame(0);
    pulse_start(0);
    run_frame(0, waited);
    check("B frame_done pulses", 32'(fd_seen), 32'd1);
    check("B frame_cnt", 32'(frame_cnt), 32'd2);

    // Pattern 2 checker with a start pulse mid-frame that must be ignored
    push_frame(2);
    pulse_start(2);
    run_frame(3000, waited);
    check("C frame_done pulses", 32'(fd_seen), 32'd1);
    check("C frame_cnt", 32'(frame_cnt), 32'd3);
    for (int i = 0; i < 300; i++) step_clk();
    check("C no extra frame vsync", 32'(vsync), 32'd0);
    check("C no extra frame busy", 32'(busy), 32'd0);
    check("C frame_cnt after idle", 32'(frame_cnt), 32'd3);

    // Asynchronous reset in the middle of an active line
    pulse_start(1);
    for (int i = 0; i < 4000 && href !== 1'b1; i++) step_clk();
    check("reset test href reached", 32'(href), 32'd1);
    repeat (37) step_clk();
    fd_seen = 0;
    #2 resetn = 1'b0;
    #1;
    check("async rst href", 32'(href), 32'd0);
    check("async rst p_data", 32'(p_data), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst frame_cnt", 32'(frame_cnt), 32'd0);
    check("async rst p_clock", 32'(p_clock), 32'd0);
    repeat (3) step_clk();
    resetn = 1'b1;
    repeat (40) step_clk();
    check("after abort frame_done", 32'(fd_seen), 32'd0);
    check("after abort vsync", 32'(vsync), 32'd0);
    push_frame(1);
    pulse_start(1);
    run_frame(0, waited);
    check("D frame_done pulses", 32'(fd_seen), 32'd1);
    check("D frame_cnt", 32'(frame_cnt), 32'd1);
    check("D busy", 32'(busy), 32'd0);

`ifdef DVP_TX_CONTINUOUS_EN
    // Continuous mode: three back-to-back frames, last one with continuous dropped
    base = int'(frame_cnt);
    continuous = 1'b1;
    push_frame(3);
    pulse_start(3);
    run_frame(0, waited);
    check("E1 frame_done pulses", 32'(fd_seen), 32'd1);
    check("E1 busy held", 32'(busy), 32'd1);
    pattern_sel = 2'd2;
    push_frame(2);
    run_frame(0, waited);
    check("E2 vsync restart wait", 32'(waited), 32'd0);
    check("E2 frame_done pulses", 32'(fd_seen), 32'd1);
    check("E2 busy held", 32'(busy), 32'd1);
    continuous = 1'b0;
    pattern_sel = 2'd1;
    push_frame(1);
    run_frame(0, waited);
    check("E3 vsync restart wait", 32'(waited), 32'd0);
    check("E3 frame_done pulses", 32'(fd_seen), 32'd1);
    check("E3 busy", 32'(busy), 32'd0);
    check("E frame_cnt", 32'(frame_cnt), 32'(base + 3));
    repeat (40) step_clk();
    check("E stays idle", 32'(vsync), 32'd0);
`else
    base = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dvp_frame_tx.md
Name: dvp_frame_tx

Overview:
- OV7670-style DVP pixel transmitter, i.e. the camera end of the parallel interface that the camera unit receives (p_clock/vsync/href/p_data).
- Generates complete RGB565 frames with programmable timing and built-in test patterns.
- Used as a camera emulator in system simulation and as an on-board loopback source, driving the SoC camera pins in place of a physical sensor.
- Purely sequential: a pixel-clock divider, a frame timing FSM and row/column/byte counters.

Parameters:
H_ACTIVE, 32, active pixels per line (each pixel = 2 bytes = 2 pclk)
V_ACTIVE, 32, active lines per frame
H_BLANK, 16, pclk periods of href low after each active line (min 1)
VSYNC_LINES, 3, line periods with vsync high (min 1)
VBP_LINES, 2, blank line periods after vsync before first active line (0 allowed)
VFP_LINES, 2, blank line periods after last active line (0 allowed)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
start  input  1  one-clk pulse; request one frame
pattern_sel  input  2  test pattern, sampled on entry to VSYNC
p_clock  output  1  pixel clock = clk/2, free-running
vsync  output  1  frame sync, active high
href  output  1  line valid, active high
p_data  output  8  pixel byte
busy  output  1  high from start acceptance until frame end
frame_done  output  1  one-clk pulse at end of frame
frame_cnt  output  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset (async, resetn low): p_clock=0, vsync=0, href=0, p_data=0, busy=0, frame_done=0, frame_cnt=0, FSM=IDLE, all counters 0, start_pend=0. Reset mid-frame aborts immediately; no frame_done.
- p_clock toggles every clk. Tick = clk edge where p_clock goes 1->0. vsync, href, p_data and the FSM update only on ticks, so all outputs are stable at the p_clock rising edge.
- Line period L = 2*H_ACTIVE + H_BLANK pclk. Every non-active line period also lasts L pclk.
- start: latched into start_pend on any clk while FSM=IDLE. busy is driven high on the same clk edge. start while busy is ignored.
- FSM, one state change per tick:
  - IDLE: on tick with start_pend, clear start_pend, latch pattern_sel, go to VSYNC; vsync=1.
  - VSYNC: vsync=1 for VSYNC_LINES*L ticks, then VBP, or ACTIVE if VBP_LINES=0.
  - VBP: vsync=0, href=0 for VBP_LINES*L ticks.
  - ACTIVE: href=1 for 2*H_ACTIVE ticks; byte 0 = pixel[15:8], byte 1 = pixel[7:0]; col increments after byte 1.
  - HBLANK: href=0, p_data=0 for H_BLANK ticks. row increments. Go to ACTIVE if row < V_ACTIVE, else to VFP (or DONE if VFP_LINES=0).
  - VFP: VFP_LINES*L ticks blank, then DONE.
  - DONE: single clk. frame_done=1, frame_cnt+1 (mod 256), busy=0, return to IDLE.
- p_data = 0 whenever href=0.
- Patterns (row, col zero-based, 16-bit pixel):
  - 0: solid 16'hF800.
  - 1: ramp, col zero-extended.
  - 2: checker, (row[3]^col[3]) ? 16'hFFFF : 16'h0000.
  - 3: {row[7:0], col[7:0]}.
- start on the same clk as DONE is ignored, since FSM is not IDLE.

Optional Feature:
- Macro DVP_TX_CONTINUOUS_EN.
- Enabled: adds input port `continuous` (1 bit). When continuous=1 in DONE, frame_done still pulses and frame_cnt increments, but the FSM re-enters VSYNC on the next tick with pattern_sel re-sampled, and busy stays high. When continuous=0, the FSM returns to IDLE.
- Disabled: port absent; behaviour exactly as above (one frame per start).

Test Plan:
1. Reset with defaults -> all outputs 0; p_clock toggles every clk after reset release; vsync/href stay 0 with no start.
2. start pulse, pattern 3 -> vsync high exactly 3*80=240 pclk, then 160 pclk blank, then 32 href pulses of 64 bytes each separated by 16 low. First bytes 00,00,00,01; line 5 first byte 05. frame_done once, frame_cnt=1, busy low.
3. Pattern 0, H_ACTIVE=4 -> each line carries F8,00 repeated 4 times; p_data=0 during HBLANK.
4. Pattern 2 -> row 0 col 8 bytes FF,FF; row 8 col 8 bytes 00,00. Second start pulse while busy -> no extra frame, frame_cnt=1.
5. Assert resetn low mid-ACTIVE -> outputs 0 asynchronously, no frame_done. A new start then gives a full frame from VSYNC.
6. DVP_TX_CONTINUOUS_EN, continuous=1 for 3 frames, then 0 -> frame_done pulses 3 times, vsync re-asserts one tick after each DONE while continuous=1, busy high throughout, frame_cnt=3.
